// File: rtl/pong_video_pkg.sv
// rtl/pong_video_pkg.sv - shared video timing constants and count type for the Pong video path
package pong_video_pkg;

    localparam int COUNT_W = 9;
    typedef logic [COUNT_W-1:0] count_t;

    // Default NTSC-ish Pong timing, in pixel clocks (H) and lines (V)
    localparam int H_TOTAL_DEF     = 455;
    localparam int V_TOTAL_DEF     = 262;
    localparam int HBLANK_END_DEF  = 80;
    localparam int HSYNC_START_DEF = 32;
    localparam int HSYNC_END_DEF   = 64;
    localparam int VBLANK_END_DEF  = 16;
    localparam int VSYNC_START_DEF = 4;
    localparam int VSYNC_END_DEF   = 8;

    // Sync must sit inside blank, blank inside the line, and the line must fit the count width
    function automatic bit timing_ok(input int total, input int blank_end,
                                     input int sync_start, input int sync_end);
        return (sync_start >= 0) && (sync_start < sync_end) && (sync_end <= blank_end) &&
               (blank_end < total) && (total <= (1 << COUNT_W));
    endfunction

endpackage

// File: rtl/pong_video_counter_if.sv
// rtl/pong_video_counter_if.sv - video timing bundle from the counter chain to the decode gates
interface pong_video_counter_if;
    import pong_video_pkg::*;

    count_t hcnt;
    count_t vcnt;
    logic   hblank;
    logic   vblank;
    logic   hsync_n;
    logic   vsync_n;
    logic   hreset;
    logic   vreset;
    logic   frame;

    modport master (
        output hcnt, vcnt, hblank, vblank, hsync_n, vsync_n, hreset, vreset, frame
    );

    modport slave (
        input hcnt, vcnt, hblank, vblank, hsync_n, vsync_n, hreset, vreset, frame
    );

endinterface

// File: rtl/pong_span_decode.sv
// rtl/pong_span_decode.sv - registered LO <= count < HI flag fed from the next count value
module pong_span_decode
    import pong_video_pkg::*;
#(
    parameter int LO = 0,
    parameter int HI = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   ce,
    input  count_t cnt_next,
    output logic   in_span
);

    // Counts restart at 0, so the reset value is simply whether 0 lies in the span
    localparam logic RST_VAL = (LO <= 0) && (HI > 0);

    localparam logic [COUNT_W:0] LO_W   = (COUNT_W+1)'(LO);
    localparam logic [COUNT_W:0] SPAN_W = (COUNT_W+1)'(HI - LO);

    // One-sided range test: counts below LO wrap to a large offset and fall outside
    logic [COUNT_W:0] offset;
    assign offset = {1'b0, cnt_next} - LO_W;

    // Register the flag on the same enabled edge that loads cnt_next into the counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_span <= RST_VAL;
        end else if (ce) begin
            in_span <= (offset < SPAN_W);
        end
    end

endmodule

// File: rtl/pong_video_counter.sv
// rtl/pong_video_counter.sv - H/V video counter chain with registered blank, sync and wrap strobes
module pong_video_counter
    import pong_video_pkg::*;
#(
    parameter int H_TOTAL     = H_TOTAL_DEF,
    parameter int V_TOTAL     = V_TOTAL_DEF,
    parameter int HBLANK_END  = HBLANK_END_DEF,
    parameter int HSYNC_START = HSYNC_START_DEF,
    parameter int HSYNC_END   = HSYNC_END_DEF,
    parameter int VBLANK_END  = VBLANK_END_DEF,
    parameter int VSYNC_START = VSYNC_START_DEF,
    parameter int VSYNC_END   = VSYNC_END_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ce,
    pong_video_counter_if.master        vid
);

    if (!timing_ok(H_TOTAL, HBLANK_END, HSYNC_START, HSYNC_END)) begin : g_bad_h_timing
        $error("pong_video_counter: horizontal timing parameters out of range");
    end
    if (!timing_ok(V_TOTAL, VBLANK_END, VSYNC_START, VSYNC_END)) begin : g_bad_v_timing
        $error("pong_video_counter: vertical timing parameters out of range");
    end

    localparam count_t H_LAST = COUNT_W'(H_TOTAL - 1);
    localparam count_t V_LAST = COUNT_W'(V_TOTAL - 1);

    count_t hcnt;
    count_t vcnt;
    count_t hcnt_next;
    count_t vcnt_next;
    logic   h_wrap;
    logic   v_wrap;
    logic   frame;
    logic   hreset;
    logic   vreset;
    logic   hblank_q;
    logic   vblank_q;
    logic   hsync_q;
    logic   vsync_q;

    // Next-count logic shared by the counters and the span decoders
    always_comb begin
        h_wrap    = (hcnt == H_LAST);
        v_wrap    = h_wrap && (vcnt == V_LAST);
        hcnt_next = h_wrap ? '0 : hcnt + 9'd1;
        vcnt_next = vcnt;
        if (v_wrap) begin
            vcnt_next = '0;
        end else if (h_wrap) begin
            vcnt_next = vcnt + 9'd1;
        end
    end

    // Counters and field parity advance only on pixel enables
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt  <= '0;
            vcnt  <= '0;
            frame <= 1'b0;
        end else if (ce) begin
            hcnt  <= hcnt_next;
            vcnt  <= vcnt_next;
            frame <= frame ^ v_wrap;
        end
    end

    // Wrap strobes reload every clk so they stay one clk wide even with ce held high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hreset <= 1'b0;
            vreset <= 1'b0;
        end else begin
            hreset <= ce && h_wrap;
            vreset <= ce && v_wrap;
        end
    end

    pong_span_decode #(.LO(0), .HI(HBLANK_END)) u_hblank (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .cnt_next (hcnt_next),
        .in_span  (hblank_q)
    );

    pong_span_decode #(.LO(HSYNC_START), .HI(HSYNC_END)) u_hsync (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .cnt_next (hcnt_next),
        .in_span  (hsync_q)
    );

    pong_span_decode #(.LO(0), .HI(VBLANK_END)) u_vblank (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .cnt_next (vcnt_next),
        .in_span  (vblank_q)
    );

    pong_span_decode #(.LO(VSYNC_START), .HI(VSYNC_END)) u_vsync (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .cnt_next (vcnt_next),
        .in_span  (vsync_q)
    );

    assign vid.hcnt    = hcnt;
    assign vid.vcnt    = vcnt;
    assign vid.hblank  = hblank_q;
    assign vid.vblank  = vblank_q;
    assign vid.hsync_n = ~hsync_q;
    assign vid.vsync_n = ~vsync_q;
    assign vid.hreset  = hreset;
    assign vid.vreset  = vreset;
    assign vid.frame   = frame;

endmodule

// File: doc/pong_video_counter.md
# pong_video_counter

Horizontal/vertical video timing counter chain for the Pong recreation. Advances once per pixel-clock enable and produces the 9-bit H and V counts that the NAND decode gates consume. Also produces the registered blank, sync and wrap strobes that drive the rest of the video path. Sits directly upstream of the count-decode gates and the net/paddle/score logic.

## Interface
Parameters:
- `H_TOTAL`, 455: pixel clocks per line; hcnt range 0..H_TOTAL-1.
- `V_TOTAL`, 262: lines per frame; vcnt range 0..V_TOTAL-1.
- `HBLANK_END`, 80: first visible hcnt.
- `HSYNC_START`, 32: first hcnt with hsync asserted.
- `HSYNC_END`, 64: first hcnt after hsync.
- `VBLANK_END`, 16: first visible vcnt.
- `VSYNC_START`, 4: first vcnt with vsync asserted.
- `VSYNC_END`, 8: first vcnt after vsync.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset. Asynchronous, active-low.
- `ce`, in, 1: pixel-clock enable. All state advances only on `clk` rising edges where `ce`=1.
- `hcnt`, out, 9: horizontal count.
- `vcnt`, out, 9: vertical count.
- `hblank`, out, 1: high for hcnt < HBLANK_END.
- `vblank`, out, 1: high for vcnt < VBLANK_END.
- `hsync_n`, out, 1: low for HSYNC_START ≤ hcnt < HSYNC_END.
- `vsync_n`, out, 1: low for VSYNC_START ≤ vcnt < VSYNC_END.
- `hreset`, out, 1: one-`clk` strobe on the enabled edge where hcnt wraps to 0.
- `vreset`, out, 1: one-`clk` strobe on the enabled edge where hcnt and vcnt both wrap to 0.
- `frame`, out, 1: toggles on every vreset (field parity for the attract/score logic).

## Operation
- **Reset** (`rst_n`=0, immediate):
  - hcnt=0, vcnt=0.
  - hblank=1, vblank=1.
  - hsync_n=1, vsync_n=1.
  - hreset=0, vreset=0, frame=0.
- **Per enabled edge:**
  - If hcnt = H_TOTAL-1: hcnt←0 and hreset←1. Otherwise hcnt←hcnt+1.
  - On an H wrap: if vcnt = V_TOTAL-1, vcnt←0, vreset←1 and frame←~frame; otherwise vcnt←vcnt+1.
  - vcnt never changes without an H wrap.
- **Registered decodes:** all decodes are computed from the next-count values and registered, so every output is consistent with the hcnt/vcnt visible in the same cycle. No combinational path runs from the counters to the outputs.
- **Strobe clearing:** hreset and vreset clear on the next `clk` edge regardless of `ce`, so each is exactly one `clk` wide even when `ce` is held high.
- **ce low:** counts, levels and frame hold; strobes clear.
- **Arithmetic:** unsigned, 9 bits, no overflow; the wrap compare is an equality against TOTAL-1. Parameters must satisfy HSYNC_START < HSYNC_END ≤ HBLANK_END < H_TOTAL ≤ 512, and the matching V constraints. Out-of-range parameters are a configuration error, flagged by an elaboration-time check.
- **Reset deassertion mid-line:** restarts from count 0 with no glitch on sync outputs.

## Timing
- Latency from an enabled edge to the updated hcnt and decodes: 0 cycles after that edge, i.e. the outputs change on the edge itself and are registered.
- Line = H_TOTAL enabled edges; frame = H_TOTAL×V_TOTAL = 119210 enabled edges at defaults.
- hreset goes high on the same edge that hcnt becomes 0.
- vreset is coincident with the hreset of line 0.
- hsync_n low width: HSYNC_END-HSYNC_START = 32 enabled edges.
- vsync_n low width: 4 lines.

## Structure
- Shared package `pong_video_pkg` holds the default timing constants and the 9-bit count width. Counter-consuming blocks import it.
- One natural sub-module, `pong_span_decode`. It takes a next count and two bounds and yields a registered in-range flag. It is instantiated for hblank, hsync, vblank and vsync.

## Test plan
- Reset release with `ce`=1 for 455 cycles: hcnt runs 0..454 then returns to 0; hreset is high for exactly 1 cycle at the wrap; vcnt steps 0→1.
- Horizontal decode: hblank falls at hcnt=80; hsync_n is low exactly for hcnt 32..63; both outputs are registered and aligned with hcnt.
- Full frame at defaults: vreset fires once per 119210 enables; frame toggles; vblank falls at vcnt=16; vsync_n is low for vcnt 4..7.
- `ce` toggling at a 1-in-3 rate, including `ce` held high across a wrap: counts advance only on enables; strobes are always 1 `clk` wide.
- `rst_n` asserted asynchronously mid-line (hcnt=200, vcnt=100) between clock edges: all outputs take reset values immediately; after release, counting resumes from 0 and no sync pulse is shortened.
- Non-default parameters (H_TOTAL=16, V_TOTAL=8, bounds scaled accordingly): wrap and decode points follow the parameters exactly.
